// File: rtl/mod_ctrl_pkg.sv
// Shared types and constants for the modulo-M counter sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mod_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrlState_t;

  // Smallest modulus that still produces a periodic wrap; smaller requests are raised to this.
  localparam int MIN_MOD = 2;

endpackage

// File: rtl/mod_counter_ctrl_if.sv
// Config offer/accept bundle carrying the modulus and event count for the next run.
// Latency: n/a (wires only).
// Backpressure: cfg_ready from the controller gates acceptance of cfg_valid.
// Ports (master drives): cfg_valid, cfg_modulus, cfg_count; (slave drives): cfg_ready.
interface mod_counter_ctrl_if #(
  parameter int WIDTH     = 3,
  parameter int CNT_WIDTH = 8
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [WIDTH-1:0]     cfg_modulus;
  logic [CNT_WIDTH-1:0] cfg_count;

  modport master (
    output cfg_valid,
    output cfg_modulus,
    output cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_modulus,
    input  cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/mod_counter_core.sv
// WIDTH-bit counter that wraps to 0 after reaching modulus-1, with sync clear and enable.
// Latency: count updates one cycle after en; wrap is a same-cycle decode of the current count.
// Backpressure: none; clr has priority over en.
// Ports: clock, reset (sync, active-low), clr, en, modulus in; count (registered), wrap out.
module mod_counter_core #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  // Compare against modulus-1 only, so the counter never relies on 2**WIDTH rollover.
  assign wrap = en && (count == (modulus - WIDTH'(1)));

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Sequencing controller for a modulo-M counter: config, start/stop, tick per wrap, stop after N ticks.
// Latency: first tick M cycles after the start edge, then one every M cycles; all outputs registered.
// Backpressure: cfg_ready is high only in IDLE or DONE; config offered during RUN is held off.
// Ports: clock, reset (sync, active-low), cfg (slave modport), start, stop in;
//        busy, tick, done, state_out, events_left, div_out out.
// Build option: define MOD_CTRL_TOGGLE_EN to build the div_out toggle flop; otherwise div_out is 0.
module mod_counter_ctrl
  import mod_ctrl_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int CNT_WIDTH   = 8,
  parameter int DEFAULT_MOD = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  mod_counter_ctrl_if.slave    cfg,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic                 tick,
  output logic                 done,
  output logic [WIDTH-1:0]     state_out,
  output logic [CNT_WIDTH-1:0] events_left,
  output logic                 div_out
);

  ctrlState_t           fsm;
  logic [WIDTH-1:0]     modQ;
  logic [CNT_WIDTH-1:0] countQ;
  logic                 cfgAccept;
  logic [WIDTH-1:0]     modIn;
  logic [CNT_WIDTH-1:0] runCount;
  logic                 coreClr;
  logic                 coreEn;
  logic                 wrap;

  assign cfg.cfg_ready = (fsm == IDLE) || (fsm == DONE);
  assign cfgAccept     = cfg.cfg_valid && cfg.cfg_ready;

  // Moduli below the minimum would never produce a periodic wrap.
  assign modIn = (cfg.cfg_modulus < WIDTH'(MIN_MOD)) ? WIDTH'(MIN_MOD) : cfg.cfg_modulus;

  // A config accepted on the start edge applies to the run that begins on that edge.
  assign runCount = cfgAccept ? cfg.cfg_count : countQ;

  // Counter restarts from 0 on run entry and on abort; it only advances while running.
  assign coreClr = ((fsm != RUN) && start) || ((fsm == RUN) && stop);
  assign coreEn  = (fsm == RUN);

  mod_counter_core #(
    .WIDTH(WIDTH)
  ) uCore (
    .clock   (clock),
    .reset   (reset),
    .clr     (coreClr),
    .en      (coreEn),
    .modulus (modQ),
    .count   (state_out),
    .wrap    (wrap)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm         <= IDLE;
      modQ        <= WIDTH'(DEFAULT_MOD);
      countQ      <= '0;
      events_left <= '0;
      tick        <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (cfgAccept) begin
        modQ   <= modIn;
        countQ <= cfg.cfg_count;
      end
      case (fsm)
        IDLE, DONE: begin
          // start wins over stop here; stop has no meaning outside RUN.
          if (start) begin
            fsm         <= RUN;
            events_left <= runCount;
            done        <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort beats a coincident final wrap: no tick, no DONE.
            fsm  <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
          end else if (wrap) begin
            tick <= 1'b1;
            // countQ is frozen during RUN, so it still holds this run's N; 0 means free-run.
            if (countQ != '0) begin
              events_left <= events_left - CNT_WIDTH'(1);
              if (events_left == CNT_WIDTH'(1)) begin
                fsm  <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end
          end
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOD_CTRL_TOGGLE_EN
  logic divQ;

  // Toggles on each wrap in RUN (period 2M); cleared on abort to IDLE, held in DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      divQ <= 1'b0;
    end else if (fsm == RUN) begin
      if (stop) begin
        divQ <= 1'b0;
      end else if (wrap) begin
        divQ <= ~divQ;
      end
    end
  end

  assign div_out = divQ;
`else
  assign div_out = 1'b0;
`endif

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Self-checking bench for mod_counter_ctrl: table of runs plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_mod_counter_ctrl;

  localparam int WIDTH     = 3;
  localparam int CNT_WIDTH = 8;
`ifdef MOD_CTRL_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 stop  = 1'b0;
  logic                 busy;
  logic                 tick;
  logic                 done;
  logic [WIDTH-1:0]     state_out;
  logic [CNT_WIDTH-1:0] events_left;
  logic                 div_out;

  mod_counter_ctrl_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) cfgIf ();

  mod_counter_ctrl #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .DEFAULT_MOD(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg         (cfgIf),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .tick        (tick),
    .done        (done),
    .state_out   (state_out),
    .events_left (events_left),
    .div_out     (div_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int modulus;
    int count;
    int period;
    int ticks;
    bit sameEdge;
  } vec_t;

  typedef struct {
    int cyc;
    int evl;
    int div;
  } exp_t;

  vec_t vecs[7];
  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entries for ticks expected after a start edge; div < 0 means not checked.
  task automatic pushTicks(input int startEdge, input int period, input int n,
                           input int count, input bit withDiv);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      e.cyc = startEdge + period * i;
      e.evl = (count == 0) ? 0 : count - i;
      e.div = withDiv ? (TOGGLE ? (i % 2) : 0) : -1;
      expQ.push_back(e);
    end
  endtask

  // Advance to the next falling edge and compare any tick against the scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clock);
    if (tick) begin
      if (expQ.size() == 0) begin
        check("tick_unexpected", cyc, -1);
      end else begin
        e = expQ.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_events_left", int'(events_left), e.evl);
        if (e.div >= 0) check("tick_div_out", int'(div_out), e.div);
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_state_out"}, int'(state_out), 0);
    check({tag, "_events_left"}, int'(events_left), 0);
    check({tag, "_div_out"}, int'(div_out), 0);
  endtask

  initial begin
    int startEdge;
    bit sawDone;

    vecs[0] = '{6, 3, 6, 3, 1'b0};
    vecs[1] = '{1, 2, 2, 2, 1'b1};
    vecs[2] = '{0, 2, 2, 2, 1'b0};
    vecs[3] = '{3, 4, 3, 4, 1'b1};
    vecs[4] = '{7, 1, 7, 1, 1'b0};
    vecs[5] = '{2, 5, 2, 5, 1'b1};
    vecs[6] = '{5, 2, 5, 2, 1'b0};

    cfgIf.cfg_valid   = 1'b0;
    cfgIf.cfg_modulus = '0;
    cfgIf.cfg_count   = '0;

    // Reset state.
    reset = 1'b0;
    step();
    step();
    checkResetOutputs("reset");
    reset = 1'b1;
    step();
    check("cfg_ready_after_reset", int'(cfgIf.cfg_ready), 1);

    // Table of complete runs, each ending in DONE.
    for (int v = 0; v < 7; v++) begin
      check("cfg_ready_idle", int'(cfgIf.cfg_ready), 1);
      cfgIf.cfg_valid   = 1'b1;
      cfgIf.cfg_modulus = WIDTH'(vecs[v].modulus);
      cfgIf.cfg_count   = CNT_WIDTH'(vecs[v].count);
      if (!vecs[v].sameEdge) begin
        step();
        cfgIf.cfg_valid = 1'b0;
      end
      start     = 1'b1;
      startEdge = cyc + 1;
      pushTicks(startEdge, vecs[v].period, vecs[v].ticks, vecs[v].count, 1'b0);
      step();
      start           = 1'b0;
      cfgIf.cfg_valid = 1'b0;
      check("busy_run", int'(busy), 1);
      check("done_cleared", int'(done), 0);
      check("cfg_ready_run", int'(cfgIf.cfg_ready), 0);
      for (int c = 0; c < vecs[v].period * vecs[v].ticks + 8 && !done; c++) step();
      check("done_set", int'(done), 1);
      check("done_cycle", cyc, startEdge + vecs[v].period * vecs[v].ticks);
      check("busy_done", int'(busy), 0);
      check("events_left_done", int'(events_left), 0);
      check("state_out_done", int'(state_out), 0);
      check("missed_ticks", expQ.size(), 0);
    end

    // Free-run M=5 for 40 cycles, with a config offer during RUN that must not be taken.
    cfgIf.cfg_valid   = 1'b1;
    cfgIf.cfg_modulus = 3'd5;
    cfgIf.cfg_count   = '0;
    start             = 1'b1;
    startEdge         = cyc + 1;
    pushTicks(startEdge, 5, 8, 0, 1'b0);
    step();
    start           = 1'b0;
    cfgIf.cfg_valid = 1'b0;
    sawDone         = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      cfgIf.cfg_valid   = (c == 10);
      cfgIf.cfg_modulus = 3'd2;
      cfgIf.cfg_count   = 8'd1;
      step();
      if (done) sawDone = 1'b1;
    end
    cfgIf.cfg_valid = 1'b0;
    check("freerun_never_done", int'(sawDone), 0);
    check("freerun_ticks", expQ.size(), 0);
    check("freerun_events_left", int'(events_left), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_state_out", int'(state_out), 0);
    check("stop_cfg_ready", int'(cfgIf.cfg_ready), 1);

    // Stop coincident with the final tick of M=4,N=2: IDLE, no tick, no DONE.
    cfgIf.cfg_valid   = 1'b1;
    cfgIf.cfg_modulus = 3'd4;
    cfgIf.cfg_count   = 8'd2;
    step();
    cfgIf.cfg_valid = 1'b0;
    start           = 1'b1;
    startEdge       = cyc + 1;
    pushTicks(startEdge, 4, 1, 2, 1'b0);
    step();
    start = 1'b0;
    while (cyc < startEdge + 7) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("final_stop_done", int'(done), 0);
    check("final_stop_busy", int'(busy), 0);
    check("final_stop_tick", int'(tick), 0);
    check("final_stop_state_out", int'(state_out), 0);
    for (int c = 0; c < 3; c++) step();
    check("final_stop_done_later", int'(done), 0);
    check("final_stop_ticks", expQ.size(), 0);

    // start and stop together in IDLE: start wins.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("start_beats_stop", int'(busy), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_after_start", int'(busy), 0);

    // Reset pulse mid-run at M=7; afterwards the default modulus 6 is back.
    cfgIf.cfg_valid   = 1'b1;
    cfgIf.cfg_modulus = 3'd7;
    cfgIf.cfg_count   = '0;
    start             = 1'b1;
    startEdge         = cyc + 1;
    pushTicks(startEdge, 7, 1, 0, 1'b0);
    step();
    start           = 1'b0;
    cfgIf.cfg_valid = 1'b0;
    while (cyc < startEdge + 9) step();
    reset = 1'b0;
    step();
    checkResetOutputs("midrun_reset");
    reset = 1'b1;
    step();
    check("midrun_reset_cfg_ready", int'(cfgIf.cfg_ready), 1);
    check("midrun_reset_ticks", expQ.size(), 0);
    start     = 1'b1;
    startEdge = cyc + 1;
    pushTicks(startEdge, 6, 2, 0, 1'b0);
    step();
    start = 1'b0;
    while (cyc < startEdge + 12) step();
    check("default_mod_ticks", expQ.size(), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // div_out with M=3,N=3 from IDLE; it holds in DONE.
    check("div_idle", int'(div_out), 0);
    cfgIf.cfg_valid   = 1'b1;
    cfgIf.cfg_modulus = 3'd3;
    cfgIf.cfg_count   = 8'd3;
    start             = 1'b1;
    startEdge         = cyc + 1;
    pushTicks(startEdge, 3, 3, 3, 1'b1);
    step();
    start           = 1'b0;
    cfgIf.cfg_valid = 1'b0;
    for (int c = 0; c < 20 && !done; c++) step();
    check("div_run_done_cycle", cyc, startEdge + 9);
    step();
    step();
    check("div_hold_done", int'(div_out), TOGGLE ? 1 : 0);
    check("div_run_ticks", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
